// File: rtl/program_loader_pkg.sv
// Shared sizing defaults and loader FSM encodings.
package program_loader_pkg;

  localparam int ADDR_WIDTH       = 16;
  localparam int REG_WIDTH        = 8;
  localparam int MEM_DEPTH        = 1024;
  localparam int INSTRUCTION_BASE = 512;

  typedef logic [2:0] ld_state_t;

  localparam ld_state_t LD_IDLE    = 3'd0;
  localparam ld_state_t LD_CLEAR   = 3'd1;
  localparam ld_state_t LD_LOAD    = 3'd2;
  localparam ld_state_t LD_VERIFY  = 3'd3;
  localparam ld_state_t LD_RELEASE = 3'd4;
  localparam ld_state_t LD_RUN     = 3'd5;
  localparam ld_state_t LD_ERROR   = 3'd6;

endpackage

// File: rtl/loader_checksum.sv
// Clearable wrap-around byte accumulator used for write/read sums.
module loader_checksum
  import program_loader_pkg::*;
#(
  parameter int W = REG_WIDTH
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] sum
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  sum <= '0;
    else if (clr)  sum <= '0;
    else if (en)   sum <= sum + din;
  end

endmodule

// File: rtl/program_loader.sv
// Holds the core in reset, clears and fills the program region,
// verifies it by read-back checksum, then releases and triggers.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int DATA_W = REG_WIDTH,
  parameter int BASE   = INSTRUCTION_BASE,
  parameter int DEPTH  = MEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              core_reset_n,
  output logic              trigger,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] count
);

  localparam int AW1 = ADDR_W + 1;
  localparam logic [ADDR_W:0]   LIMIT  = AW1'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

  ld_state_t         state;
  logic [ADDR_W-1:0] vidx;
  logic              a0;
  logic              a1;
  logic [DATA_W-1:0] sum_w;
  logic [DATA_W-1:0] sum_r;
  logic [ADDR_W:0]   next_a;
  logic              take;
  logic              full;
  logic              go;
  logic              wr_en;
  logic              rd_en;

  // One extra bit so BASE+count can reach DEPTH without wrapping.
  assign next_a = {1'b0, BASE_A} + {1'b0, count};
  assign full   = (next_a == LIMIT);
  assign take   = s_valid && s_ready;
  assign wr_en  = take && !full;
  assign rd_en  = (state == LD_VERIFY) && a1;
  assign go     = start && ((state == LD_IDLE) ||
                            (state == LD_RUN)  ||
                            (state == LD_ERROR));

  loader_checksum #(.W(DATA_W)) u_sum_w (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (go),
    .en      (wr_en),
    .din     (s_data),
    .sum     (sum_w)
  );

  loader_checksum #(.W(DATA_W)) u_sum_r (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (go),
    .en      (rd_en),
    .din     (mem_dout),
    .sum     (sum_r)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= LD_IDLE;
      core_reset_n <= 1'b0;
      trigger      <= 1'b0;
      s_ready      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_din      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      count        <= '0;
      vidx         <= '0;
      a0           <= 1'b0;
      a1           <= 1'b0;
    end else begin
      trigger <= 1'b0;
      case (state)
        LD_IDLE, LD_RUN, LD_ERROR: begin
          if (go) begin
            state        <= LD_CLEAR;
            core_reset_n <= 1'b0;
            busy         <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            count        <= '0;
            mem_we       <= 1'b1;
            mem_addr     <= BASE_A;
            mem_din      <= '0;
          end
        end
        LD_CLEAR: begin
          if (mem_addr == LAST_A) begin
            state    <= LD_LOAD;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            s_ready  <= 1'b1;
          end else begin
            mem_addr <= mem_addr + ONE;
          end
        end
        LD_LOAD: begin
          mem_we   <= 1'b0;
          mem_addr <= '0;
          mem_din  <= '0;
          if (take && full) begin
            state   <= LD_ERROR;
            s_ready <= 1'b0;
            busy    <= 1'b0;
            error   <= 1'b1;
          end else if (take) begin
            mem_we   <= 1'b1;
            mem_addr <= BASE_A + count;
            mem_din  <= s_data;
            count    <= count + ONE;
            if (s_last) begin
              state   <= LD_VERIFY;
              s_ready <= 1'b0;
              vidx    <= '0;
              a0      <= 1'b0;
              a1      <= 1'b0;
            end
          end
        end
        LD_VERIFY: begin
          // a0: read address on the bus, a1: its data on mem_dout
          mem_we  <= 1'b0;
          mem_din <= '0;
          a1      <= a0;
          if (vidx != count) begin
            mem_addr <= BASE_A + vidx;
            vidx     <= vidx + ONE;
            a0       <= 1'b1;
          end else begin
            mem_addr <= '0;
            a0       <= 1'b0;
          end
          if ((vidx == count) && !a0 && !a1) begin
            if (sum_r == sum_w) begin
              state        <= LD_RELEASE;
              core_reset_n <= 1'b1;
            end else begin
              state <= LD_ERROR;
              busy  <= 1'b0;
              error <= 1'b1;
            end
          end
        end
        LD_RELEASE: begin
          state   <= LD_RUN;
          trigger <= 1'b1;
          done    <= 1'b1;
          busy    <= 1'b0;
        end
        default: state <= LD_IDLE;
      endcase
    end
  end

endmodule
